// File: rtl/common_pkg.sv
// Shared types for the instruction-fetch path.
// instruction_type: one 32-bit instruction window as returned to fetch.
package common;

    typedef logic [31:0] instruction_type;

endpackage

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder with a single held word.
// Ports: fetch side req_valid/req_addr/flush/invalidate -> busy,
//   rsp_valid/rsp_data/misalign_err; memory side mem_req/mem_addr ->
//   mem_rvalid/mem_rdata. Clock clk, async active-low reset reset_n.
module imem_fetch_responder
    import common::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    input  logic [31:0]     req_addr,
    input  logic            flush,
    input  logic            invalidate,
    output logic            busy,
    output logic            rsp_valid,
    output instruction_type rsp_data,
    output logic            misalign_err,
    output logic            mem_req,
    output logic [29:0]     mem_addr,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_LO = 2'd1,
        READ_HI = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] data;
    } hold_t;

    state_e          state_q, state_d;
    logic [29:0]     word_q, word_d;
    logic            half_q, half_d;
    logic            cancel_q, cancel_d;
    logic            drop_q, drop_d;
    hold_t           hold_q, hold_d;
    logic            rsp_valid_q, rsp_valid_d;
    instruction_type rsp_data_q, rsp_data_d;
    logic            misalign_q, misalign_d;

    logic [29:0]     word_hi;
    logic            hit;
    logic            cancel_now;
    logic            drop_now;

    assign word_hi    = word_q + 30'd1;
    // A same-cycle invalidate wins over a lookup.
    assign hit        = hold_q.valid && !invalidate
                        && (hold_q.tag == req_addr[31:2]);
    assign cancel_now = cancel_q || flush;
    assign drop_now   = drop_q || invalidate;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        half_d      = half_q;
        cancel_d    = cancel_q;
        drop_d      = drop_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        misalign_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // flush in IDLE has no in-flight read to cancel.
                if (req_valid) begin
                    word_d   = req_addr[31:2];
                    half_d   = req_addr[1];
                    cancel_d = 1'b0;
                    drop_d   = 1'b0;
                    if (req_addr[0]) begin
                        misalign_d = 1'b1;
                        rsp_data_d = '0;
                    end else if (hit && !req_addr[1]) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = hold_q.data;
                    end else if (hit) begin
                        state_d = READ_HI;
                    end else begin
                        state_d = READ_LO;
                    end
                end
            end
            READ_LO: begin
                cancel_d = cancel_now;
                drop_d   = drop_now;
                if (mem_rvalid) begin
                    // Low word is kept even when dropped: READ_HI needs it.
                    hold_d.data  = mem_rdata;
                    hold_d.tag   = word_q;
                    hold_d.valid = !drop_now;
                    if (half_q && !cancel_now) begin
                        state_d = READ_HI;
                    end else begin
                        state_d = IDLE;
                        if (!cancel_now) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = mem_rdata;
                        end
                    end
                end
            end
            READ_HI: begin
                cancel_d = cancel_now;
                drop_d   = drop_now;
                if (mem_rvalid) begin
                    hold_d.data  = mem_rdata;
                    hold_d.tag   = word_hi;
                    hold_d.valid = !drop_now;
                    state_d      = IDLE;
                    if (!cancel_now) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {mem_rdata[15:0],
                                       hold_q.data[31:16]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (invalidate) begin
            hold_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            half_q      <= 1'b0;
            cancel_q    <= 1'b0;
            drop_q      <= 1'b0;
            hold_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            half_q      <= half_d;
            cancel_q    <= cancel_d;
            drop_q      <= drop_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            misalign_q  <= misalign_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign mem_req      = (state_q != IDLE);
    assign mem_addr     = (state_q == READ_HI) ? word_hi : word_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: directed scenarios plus
// randomized requests against a word-level reference model.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        invalidate = 1'b0;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        misalign_err;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    imem_fetch_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .flush        (flush),
        .invalidate   (invalidate),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .misalign_err (misalign_err),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mread(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    int          lat = 2;
    int          mcnt = 0;
    int          nreads = 0;
    logic [29:0] rd_log [$];

    // rvalid arrives in the lat-th cycle that mem_req is held.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (!reset_n || !mem_req) begin
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt >= lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mread(mem_addr);
                mcnt       = 0;
                nreads++;
                rd_log.push_back(mem_addr);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        bit          mis;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb [$];

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (rsp_valid || misalign_err)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got valid=%b mis=%b expected none",
                         rsp_valid, misalign_err);
            end else begin
                e = sb.pop_front();
                check("rsp_mis", {31'b0, misalign_err}, {31'b0, e.mis});
                check("rsp_valid", {31'b0, rsp_valid}, {31'b0, !e.mis});
                check(e.mis ? "mis_data" : "rsp_data", rsp_data, e.data);
                check("rsp_cycle", cyc, e.at);
            end
        end
    end

    // ---------------- reference model ----------------
    bit          hv = 0;
    logic [29:0] ht = '0;
    logic [31:0] hd = '0;

    // Returns the words the request must read and its response window.
    task automatic model_req(input logic [31:0] a, input bit fl,
                             input bit inv, output int nr,
                             output logic [31:0] d);
        logic [29:0] w;
        logic [29:0] rds [$];
        w  = a[31:2];
        nr = 0;
        d  = '0;
        if (a[0]) return;
        if (!a[1]) begin
            d = mread(w);
            if (!(hv && ht == w)) rds.push_back(w);
        end else begin
            d = {mread(w + 30'd1) >> 0, 16'h0} == 0 ? '0 : '0;
            d = {mread(w + 30'd1) & 32'h0000FFFF, 16'h0} >> 0;
            d = (mread(w + 30'd1) << 16) | (mread(w) >> 16);
            if (!(hv && ht == w)) rds.push_back(w);
            rds.push_back(w + 30'd1);
        end
        if (fl && rds.size() > 1) rds = rds[0:0];
        nr = rds.size();
        if (nr > 0) begin
            hv = !inv;
            ht = rds[nr-1];
            hd = mread(rds[nr-1]);
        end
    endtask

    // Issue one request at a negedge; returns at a negedge.
    task automatic do_req(input logic [31:0] a, input int l,
                          input bit fl, input bit inv);
        int          nr;
        int          n0;
        int          k;
        logic [31:0] d;
        lat = l;
        n0  = nreads;
        model_req(a, fl, inv, nr, d);
        if (!(fl && nr > 0))
            sb.push_back('{a[0], d, cyc + 1 + nr * l});
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            if (k == 0) begin
                flush      = fl;
                invalidate = inv;
            end
            @(negedge clk);
            flush      = 1'b0;
            invalidate = 1'b0;
            k++;
        end
        if (k >= 200) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got busy for %0d cycles expected <200", k);
        end
        @(negedge clk);
        check("mem_reads", nreads - n0, nr);
    endtask

    task automatic do_inval(input logic [29:0] w, input logic [31:0] v);
        invalidate = 1'b1;
        mem[w] = v;
        hv = 0;
        @(negedge clk);
        invalidate = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [29:0] w;
        logic [31:0] a;
        mem[30'h0]        = 32'h00A00093;
        mem[30'h1]        = 32'h12345678;
        mem[30'h3FFFFFFF] = 32'hCAFEBABE;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Cold word fetch, upper-half fetch, then a hit.
        rd_log.delete();
        do_req(32'h0, 2, 0, 0);
        do_req(32'h2, 2, 0, 0);
        check("rd_addr_w1", {2'b0, rd_log[rd_log.size()-1]}, 32'h1);
        do_req(32'h4, 2, 0, 0);

        // Window straddling the top of the address space.
        do_inval(30'h5, 32'h0BADF00D);
        rd_log.delete();
        do_req(32'hFFFFFFFE, 2, 0, 0);
        check("wrap_nreads", rd_log.size(), 32'd2);
        if (rd_log.size() == 2) begin
            check("wrap_rd0", {2'b0, rd_log[0]}, 32'h3FFFFFFF);
            check("wrap_rd1", {2'b0, rd_log[1]}, 32'h0);
        end

        // Flushed miss still fills the held word.
        do_req(32'h8, 3, 1, 0);
        do_req(32'h8, 2, 0, 0);

        // Misaligned request, then invalidate forces a refetch.
        do_req(32'h3, 2, 0, 0);
        do_req(32'h4, 1, 0, 0);
        do_inval(30'h1, 32'hFEEDC0DE);
        do_req(32'h4, 2, 0, 0);

        // Invalidate during a read: data delivered, not retained.
        do_req(32'h10, 3, 0, 1);
        do_req(32'h10, 1, 0, 0);

        // Reset mid-read abandons the access.
        lat = 6;
        req_valid = 1'b1;
        req_addr  = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        hv = 0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        do_req(32'h20, 2, 0, 0);

        // Randomized traffic over a small hot set plus the top words.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 8)
                w = 30'($urandom_range(0, 7));
            else
                w = 30'h3FFFFFFF - 30'($urandom_range(0, 1));
            a = {w, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0)};
            if ($urandom_range(0, 9) == 0)
                do_inval(30'($urandom_range(0, 7)), $urandom);
            do_req(a, $urandom_range(1, 3),
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) == 0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
